// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronizes and debounces active-low push buttons and emits a
//            clean level plus one-cycle press / release / long-press pulses.
//            Define BTN_AUTOREPEAT_EN to re-pulse press while a long hold lasts.
// Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 12_500_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_n,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] release_pulse,   // `release` is a reserved word
   output logic [N_BTN-1:0] long_press
);

   localparam int c_DCNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int c_HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int c_HCNT_W   = $clog2(c_HOLD_MAX);

   localparam logic [c_DCNT_W-1:0] c_DCNT_MAX = c_DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_DCNT_W-1:0] c_DCNT_ONE = c_DCNT_W'(1);
   localparam logic [c_HCNT_W-1:0] c_LONG_MAX = c_HCNT_W'(LONG_CYCLES - 1);
   localparam logic [c_HCNT_W-1:0] c_HCNT_ONE = c_HCNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [c_HCNT_W-1:0] c_REP_MAX  = c_HCNT_W'(REPEAT_CYCLES - 1);
`endif

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_HELD = 2'd1;
   localparam logic [1:0] c_LONG = 2'd2;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic                r_sync1;
      logic                r_sync2;
      logic [c_DCNT_W-1:0] r_dcnt;
      logic                r_level;
      logic                r_press;
      logic                r_release;
      logic                r_long;
      logic [1:0]          r_state;
      logic [c_HCNT_W-1:0] r_hcnt;
      logic                w_accept;
      logic                w_acc_press;
      logic                w_acc_release;

      // A change is accepted on the sample that completes the stable run.
      assign w_accept      = (r_sync2 != r_level) && (r_dcnt == c_DCNT_MAX);
      assign w_acc_press   = w_accept &  r_sync2;
      assign w_acc_release = w_accept & ~r_sync2;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_state   <= c_IDLE;
            r_hcnt    <= '0;
         end else begin
            r_sync1   <= ~btn_n[i];
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            if (r_sync2 == r_level) begin
               r_dcnt <= '0;
            end else if (r_dcnt != c_DCNT_MAX) begin
               r_dcnt <= r_dcnt + c_DCNT_ONE;
            end else begin
               r_dcnt  <= '0;
               r_level <= r_sync2;
            end

            // Release wins over a long or repeat pulse falling on the same edge.
            case (r_state)
               c_IDLE: begin
                  if (w_acc_press) begin
                     r_state <= c_HELD;
                     r_hcnt  <= '0;
                     r_press <= 1'b1;
                  end
               end
               c_HELD: begin
                  if (w_acc_release) begin
                     r_state   <= c_IDLE;
                     r_release <= 1'b1;
                  end else if (r_hcnt == c_LONG_MAX) begin
                     r_state <= c_LONG;
                     r_long  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                     r_hcnt  <= '0;
`endif
                  end else begin
                     r_hcnt <= r_hcnt + c_HCNT_ONE;
                  end
               end
               c_LONG: begin
                  if (w_acc_release) begin
                     r_state   <= c_IDLE;
                     r_release <= 1'b1;
                  end
`ifdef BTN_AUTOREPEAT_EN
                  else if (r_hcnt == c_REP_MAX) begin
                     r_press <= 1'b1;
                     r_hcnt  <= '0;
                  end else begin
                     r_hcnt <= r_hcnt + c_HCNT_ONE;
                  end
`endif
               end
               default: begin
                  r_state <= c_IDLE;
               end
            endcase
         end
      end

      assign level[i]         = r_level;
      assign press[i]         = r_press;
      assign release_pulse[i] = r_release;
      assign long_press[i]    = r_long;
   end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Scoreboard bench for button_conditioner (DEBOUNCE=4, LONG=20,
//            REPEAT=5); honours BTN_AUTOREPEAT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

   localparam int c_N     = 2;
   localparam int c_DEB   = 4;
   localparam int c_LONG  = 20;
   localparam int c_REP   = 5;
   localparam int c_LAT   = c_DEB + 2;

   localparam int c_K_PRESS   = 0;
   localparam int c_K_RELEASE = 1;
   localparam int c_K_LONG    = 2;

   typedef struct {
      int kind;
      int bit_idx;
      int at_cyc;
   } ev_t;

   logic           clk;
   logic           reset;
   logic [c_N-1:0] btn_n;
   logic [c_N-1:0] level;
   logic [c_N-1:0] press;
   logic [c_N-1:0] release_pulse;
   logic [c_N-1:0] long_press;

   int  cyc;
   int  n_compared;
   int  n_mismatched;
   ev_t exp_q[$];

   button_conditioner #(
      .N_BTN          (c_N),
      .DEBOUNCE_CYCLES(c_DEB),
      .LONG_CYCLES    (c_LONG),
      .REPEAT_CYCLES  (c_REP)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .btn_n        (btn_n),
      .level        (level),
      .press        (press),
      .release_pulse(release_pulse),
      .long_press   (long_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input int got, input int exp);
      n_compared++;
      if (got != exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int b, input int at);
      ev_t e;
      e.kind    = kind;
      e.bit_idx = b;
      e.at_cyc  = at;
      exp_q.push_back(e);
   endtask

   // Expected pulses of one hold: press at p, events strictly before cutoff r.
   task automatic push_hold(input int b, input int p, input int r);
      push_ev(c_K_PRESS, b, p);
      if (p + c_LONG < r) begin
         push_ev(c_K_LONG, b, p + c_LONG);
`ifdef BTN_AUTOREPEAT_EN
         for (int t = p + c_LONG + c_REP; t < r; t += c_REP) push_ev(c_K_PRESS, b, t);
`endif
      end
   endtask

   task automatic match_event(input int kind, input int b, input int obs);
      int    idx;
      string tag;
      idx = -1;
      tag = (kind == c_K_PRESS) ? "press" : (kind == c_K_RELEASE) ? "release" : "long_press";
      for (int j = 0; j < exp_q.size(); j++) begin
         if (idx < 0 && exp_q[j].kind == kind && exp_q[j].bit_idx == b) idx = j;
      end
      if (idx < 0) begin
         check_value($sformatf("%s[%0d]_unexpected", tag, b), obs, 0);
      end else begin
         check_value($sformatf("%s[%0d]_cycle", tag, b), cyc, exp_q[idx].at_cyc);
         exp_q.delete(idx);
      end
   endtask

   always @(posedge clk) begin
      #1;
      for (int b = 0; b < c_N; b++) begin
         if (press[b])         match_event(c_K_PRESS,   b, int'(press[b]));
         if (release_pulse[b]) match_event(c_K_RELEASE, b, int'(release_pulse[b]));
         if (long_press[b])    match_event(c_K_LONG,    b, int'(long_press[b]));
      end
   end

   task automatic drain(input string tag);
      repeat (12) @(negedge clk);
      check_value({tag, "_missing_events"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int c;
      n_compared   = 0;
      n_mismatched = 0;
      reset = 1'b1;
      btn_n = 2'b11;
      #1;
      reset = 1'b0;
      btn_n = 2'b00;

      // Reset held with both buttons pressed: everything stays quiet.
      repeat (4) begin
         @(negedge clk);
         check_value("reset_outputs", int'({level, press, release_pulse, long_press}), 0);
      end
      @(negedge clk);
      c = cyc;
      reset = 1'b1;
      push_hold(0, c + c_LAT, c + 10 + c_LAT);
      push_hold(1, c + c_LAT, c + 10 + c_LAT);
      push_ev(c_K_RELEASE, 0, c + 10 + c_LAT);
      push_ev(c_K_RELEASE, 1, c + 10 + c_LAT);
      repeat (c_LAT) @(negedge clk);
      check_value("level_after_reset", int'(level), 3);
      repeat (10 - c_LAT) @(negedge clk);
      btn_n = 2'b11;
      drain("reset_release");
      check_value("level_idle", int'(level), 0);

      // Clean tap on button 0.
      c = cyc;
      btn_n[0] = 1'b0;
      push_hold(0, c + c_LAT, c + 10 + c_LAT);
      push_ev(c_K_RELEASE, 0, c + 10 + c_LAT);
      repeat (8) @(negedge clk);
      check_value("level_tap", int'(level), 1);
      repeat (2) @(negedge clk);
      btn_n[0] = 1'b1;
      drain("tap");

      // Bounce: 3 low / 1 high, five times, then a steady low.
      repeat (5) begin
         btn_n[0] = 1'b0;
         repeat (3) @(negedge clk);
         btn_n[0] = 1'b1;
         @(negedge clk);
      end
      check_value("level_bounce", int'(level), 0);
      c = cyc;
      btn_n[0] = 1'b0;
      push_hold(0, c + c_LAT, c + 10 + c_LAT);
      push_ev(c_K_RELEASE, 0, c + 10 + c_LAT);
      repeat (10) @(negedge clk);
      btn_n[0] = 1'b1;
      drain("bounce");

      // Long press on button 1.
      c = cyc;
      btn_n[1] = 1'b0;
      push_hold(1, c + c_LAT, c + 40 + c_LAT);
      push_ev(c_K_RELEASE, 1, c + 40 + c_LAT);
      repeat (40) @(negedge clk);
      check_value("level_long", int'(level), 2);
      btn_n[1] = 1'b1;
      drain("long");

      // Reset in the middle of a hold, button still pressed afterwards.
      c = cyc;
      btn_n[0] = 1'b0;
      push_hold(0, c + c_LAT, c + 11);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      check_value("midreset_async", int'({level, press, release_pulse, long_press}), 0);
      repeat (3) begin
         @(negedge clk);
         check_value("midreset_outputs", int'({level, press, release_pulse, long_press}), 0);
      end
      c = cyc;
      reset = 1'b1;
      push_hold(0, c + c_LAT, c + 35 + c_LAT);
      push_ev(c_K_RELEASE, 0, c + 35 + c_LAT);
      repeat (35) @(negedge clk);
      btn_n[0] = 1'b1;
      drain("midreset");

      // Both buttons pressed and released together.
      c = cyc;
      btn_n = 2'b00;
      push_hold(0, c + c_LAT, c + 8 + c_LAT);
      push_hold(1, c + c_LAT, c + 8 + c_LAT);
      push_ev(c_K_RELEASE, 0, c + 8 + c_LAT);
      push_ev(c_K_RELEASE, 1, c + 8 + c_LAT);
      repeat (8) @(negedge clk);
      btn_n = 2'b11;
      drain("simultaneous");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
